// File: rtl/match_controller_pkg.sv
// Shared definitions for the match controller and the fighter FSM block:
// fighter state codes, match phase codes and sprite geometry.
package match_controller_pkg;

    localparam int CHAR_WIDTH = 128;

    typedef enum logic [3:0] {
        FS_IDLE          = 4'd0,
        FS_LEFT          = 4'd1,
        FS_RIGHT         = 4'd2,
        FS_ATK1_STARTUP  = 4'd3,
        FS_ATK1_ACTIVE   = 4'd4,
        FS_ATK1_RECOVERY = 4'd5,
        FS_ATK2_STARTUP  = 4'd6,
        FS_ATK2_ACTIVE   = 4'd7,
        FS_ATK2_RECOVERY = 4'd8,
        FS_DAMAGE        = 4'd9,
        FS_BLOCK         = 4'd10
    } fighter_state_e;

    typedef enum logic [2:0] {
        PH_MENU       = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_ROUND_END  = 3'd3,
        PH_MATCH_OVER = 3'd4
    } match_phase_e;

    function automatic logic is_attack_active(input logic [3:0] st);
        return (st == FS_ATK1_ACTIVE) || (st == FS_ATK2_ACTIVE);
    endfunction

endpackage

// File: rtl/match_controller_hit_judge.sv
// Combinational hit judge for one attacker/defender pair: facing, edge gap,
// reach test and block detection. Instantiated once per attack direction.
module match_controller_hit_judge
    import match_controller_pkg::*;
#(
    parameter int ATT_IS_P1  = 1,
    parameter int REACH_ATK1 = 24,
    parameter int REACH_ATK2 = 40
) (
    input  logic [9:0] att_x_i,
    input  logic [9:0] def_x_i,
    input  logic [3:0] att_state_i,
    input  logic [3:0] def_state_i,
    input  logic       att_latch_i,
    output logic       connect_o,
    output logic       blocked_o
);

    localparam int HALF_W = CHAR_WIDTH / 2;

    logic [10:0] att_centre;
    logic [10:0] def_centre;
    logic [10:0] att_near;
    logic [10:0] def_near;
    logic [10:0] gap;
    logic [10:0] reach;
    logic        faces_right;

    always_comb begin
        att_centre = {1'b0, att_x_i} + 11'(HALF_W);
        def_centre = {1'b0, def_x_i} + 11'(HALF_W);

        // Fighter 1 faces right only on a strict centre comparison; fighter 2
        // always faces the other way, so equal centres leave them facing apart.
        if (ATT_IS_P1 != 0) begin
            faces_right = att_centre < def_centre;
        end else begin
            faces_right = !(def_centre < att_centre);
        end

        if (faces_right) begin
            att_near = {1'b0, att_x_i} + 11'(CHAR_WIDTH);
            def_near = {1'b0, def_x_i};
            gap      = (def_near > att_near) ? (def_near - att_near) : 11'd0;
        end else begin
            att_near = {1'b0, att_x_i};
            def_near = {1'b0, def_x_i} + 11'(CHAR_WIDTH);
            gap      = (att_near > def_near) ? (att_near - def_near) : 11'd0;
        end

        case (att_state_i)
            FS_ATK1_ACTIVE: reach = 11'(REACH_ATK1);
            FS_ATK2_ACTIVE: reach = 11'(REACH_ATK2);
            default:        reach = 11'd0;
        endcase

        connect_o = is_attack_active(att_state_i) && !att_latch_i && (gap <= reach);
        // Blocking means walking away from the attacker, which is the attacker's facing direction.
        blocked_o = connect_o &&
                    (def_state_i == (faces_right ? FS_RIGHT : FS_LEFT));
    end

endmodule

// File: rtl/match_controller.sv
// Match sequencer: menu, countdown, fight, round end and match over, with hit
// judging, health/round scoring and the fighter FSM hold.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int REACH_ATK1       = 24,
    parameter int REACH_ATK2       = 40,
    parameter int MAX_HEALTH       = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int COUNTDOWN_FRAMES = 120,
    parameter int ROUND_END_FRAMES = 90
) (
    input  logic       clk_game,
    input  logic       reset,
    input  logic       start_button,
    input  logic [3:0] state_p1,
    input  logic [3:0] state_p2,
    input  logic [9:0] char1_x,
    input  logic [9:0] char2_x,
    output logic       fsm_hold,
    output logic [2:0] match_state,
    output logic [1:0] health_p1,
    output logic [1:0] health_p2,
    output logic [1:0] rounds_p1,
    output logic [1:0] rounds_p2,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic       block_p1,
    output logic       block_p2,
    output logic [1:0] winner
);

    localparam int TIMER_MAX = (COUNTDOWN_FRAMES > ROUND_END_FRAMES) ?
                               COUNTDOWN_FRAMES : ROUND_END_FRAMES;
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    localparam logic [TIMER_W-1:0] CD_LAST     = TIMER_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [TIMER_W-1:0] RE_LAST     = TIMER_W'(ROUND_END_FRAMES - 1);
    localparam logic [1:0]         HEALTH_FULL = 2'(MAX_HEALTH);
    localparam logic [1:0]         ROUNDS_WIN  = 2'(ROUNDS_TO_WIN);

    match_phase_e       phase_q;
    logic [TIMER_W-1:0] timer_q;
    logic               hold_q;
    logic [1:0]         health_p1_q, health_p1_d;
    logic [1:0]         health_p2_q, health_p2_d;
    logic [1:0]         rounds_p1_q;
    logic [1:0]         rounds_p2_q;
    logic [1:0]         winner_q;
    logic               hit_p1_q, hit_p1_d;
    logic               hit_p2_q, hit_p2_d;
    logic               block_p1_q, block_p1_d;
    logic               block_p2_q, block_p2_d;
    logic               latch_p1_q, latch_p1_d;
    logic               latch_p2_q, latch_p2_d;
    logic               start_prev_q;

    logic start_rise;
    logic ko;
    logic judging;
    logic p1_connect, p1_blocked;
    logic p2_connect, p2_blocked;

    match_controller_hit_judge #(
        .ATT_IS_P1 (1),
        .REACH_ATK1(REACH_ATK1),
        .REACH_ATK2(REACH_ATK2)
    ) u_judge_p1_attacks (
        .att_x_i    (char1_x),
        .def_x_i    (char2_x),
        .att_state_i(state_p1),
        .def_state_i(state_p2),
        .att_latch_i(latch_p1_q),
        .connect_o  (p1_connect),
        .blocked_o  (p1_blocked)
    );

    match_controller_hit_judge #(
        .ATT_IS_P1 (0),
        .REACH_ATK1(REACH_ATK1),
        .REACH_ATK2(REACH_ATK2)
    ) u_judge_p2_attacks (
        .att_x_i    (char2_x),
        .def_x_i    (char1_x),
        .att_state_i(state_p2),
        .def_state_i(state_p1),
        .att_latch_i(latch_p2_q),
        .connect_o  (p2_connect),
        .blocked_o  (p2_blocked)
    );

    // Hit outcomes. The cycle that detects a KO is the exit cycle of FIGHT, so
    // no further damage or pulses are produced in it.
    always_comb begin
        start_rise = start_button && !start_prev_q;
        ko         = (health_p1_q == 2'd0) || (health_p2_q == 2'd0);
        judging    = (phase_q == PH_FIGHT) && !ko;

        hit_p2_d   = judging && p1_connect && !p1_blocked;
        block_p2_d = judging && p1_connect && p1_blocked;
        hit_p1_d   = judging && p2_connect && !p2_blocked;
        block_p1_d = judging && p2_connect && p2_blocked;

        health_p1_d = health_p1_q;
        if (hit_p1_d && (health_p1_q != 2'd0)) begin
            health_p1_d = health_p1_q - 2'd1;
        end
        health_p2_d = health_p2_q;
        if (hit_p2_d && (health_p2_q != 2'd0)) begin
            health_p2_d = health_p2_q - 2'd1;
        end

        latch_p1_d = latch_p1_q;
        if (!is_attack_active(state_p1)) begin
            latch_p1_d = 1'b0;
        end else if (judging && p1_connect) begin
            latch_p1_d = 1'b1;
        end
        latch_p2_d = latch_p2_q;
        if (!is_attack_active(state_p2)) begin
            latch_p2_d = 1'b0;
        end else if (judging && p2_connect) begin
            latch_p2_d = 1'b1;
        end
    end

    // All outputs are registered; pulses are single-cycle strobes with no
    // handshake, and match_state is the phase register itself.
    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            phase_q      <= PH_MENU;
            timer_q      <= '0;
            hold_q       <= 1'b1;
            health_p1_q  <= HEALTH_FULL;
            health_p2_q  <= HEALTH_FULL;
            rounds_p1_q  <= 2'd0;
            rounds_p2_q  <= 2'd0;
            winner_q     <= 2'd0;
            hit_p1_q     <= 1'b0;
            hit_p2_q     <= 1'b0;
            block_p1_q   <= 1'b0;
            block_p2_q   <= 1'b0;
            latch_p1_q   <= 1'b0;
            latch_p2_q   <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_prev_q <= start_button;
            latch_p1_q   <= latch_p1_d;
            latch_p2_q   <= latch_p2_d;
            hit_p1_q     <= hit_p1_d;
            hit_p2_q     <= hit_p2_d;
            block_p1_q   <= block_p1_d;
            block_p2_q   <= block_p2_d;

            case (phase_q)
                PH_MENU: begin
                    if (start_rise) begin
                        phase_q     <= PH_COUNTDOWN;
                        timer_q     <= '0;
                        health_p1_q <= HEALTH_FULL;
                        health_p2_q <= HEALTH_FULL;
                        rounds_p1_q <= 2'd0;
                        rounds_p2_q <= 2'd0;
                        winner_q    <= 2'd0;
                    end
                end

                PH_COUNTDOWN: begin
                    if (timer_q == CD_LAST) begin
                        timer_q <= '0;
                        phase_q <= PH_FIGHT;
                        hold_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end

                PH_FIGHT: begin
                    health_p1_q <= health_p1_d;
                    health_p2_q <= health_p2_d;
                    if (ko) begin
                        phase_q <= PH_ROUND_END;
                        hold_q  <= 1'b1;
                        timer_q <= '0;
                        // A double KO is a draw and awards nothing.
                        if ((health_p1_q == 2'd0) && (health_p2_q != 2'd0)) begin
                            rounds_p2_q <= rounds_p2_q + 2'd1;
                        end else if ((health_p2_q == 2'd0) && (health_p1_q != 2'd0)) begin
                            rounds_p1_q <= rounds_p1_q + 2'd1;
                        end
                    end
                end

                PH_ROUND_END: begin
                    if (timer_q == RE_LAST) begin
                        timer_q <= '0;
                        if ((rounds_p1_q == ROUNDS_WIN) || (rounds_p2_q == ROUNDS_WIN)) begin
                            phase_q  <= PH_MATCH_OVER;
                            winner_q <= (rounds_p1_q == ROUNDS_WIN) ? 2'd1 : 2'd2;
                        end else begin
                            phase_q     <= PH_COUNTDOWN;
                            health_p1_q <= HEALTH_FULL;
                            health_p2_q <= HEALTH_FULL;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end

                PH_MATCH_OVER: begin
                    if (start_rise) begin
                        phase_q <= PH_MENU;
                    end
                end

                default: begin
                    phase_q <= PH_MENU;
                    hold_q  <= 1'b1;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign fsm_hold    = hold_q;
    assign match_state = phase_q;
    assign health_p1   = health_p1_q;
    assign health_p2   = health_p2_q;
    assign rounds_p1   = rounds_p1_q;
    assign rounds_p2   = rounds_p2_q;
    assign hit_p1      = hit_p1_q;
    assign hit_p2      = hit_p2_q;
    assign block_p1    = block_p1_q;
    assign block_p2    = block_p2_q;
    assign winner      = winner_q;

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a single match for the two fighter FSMs: menu, pre-round countdown, fight, round end and match over.
- During the fight it judges hits from the fighters' state codes and x-positions, keeps health and round scores, and decides the winner.
- Holds the fighter FSMs in reset outside the FIGHT phase through fsm_hold.
- Sits between the fighter FSM block and the renderer/score display.

Parameters:
- CHAR_WIDTH, 128: sprite width in pixels, used for edge and centre math.
- REACH_ATK1, 24: hit reach of attack 1, in pixels beyond the attacker's facing edge.
- REACH_ATK2, 40: hit reach of attack 2, in pixels.
- MAX_HEALTH, 3: hits needed to end a round.
- ROUNDS_TO_WIN, 2: rounds needed to win the match.
- COUNTDOWN_FRAMES, 120: length of the COUNTDOWN phase, in clk_game cycles.
- ROUND_END_FRAMES, 90: length of the ROUND_END phase, in clk_game cycles.

Ports:
- clk_game  in  1  frame-rate game clock
- reset  in  1  asynchronous, active-high
- start_button  in  1  level input; rising edge detected internally
- state_p1  in  4  fighter 1 state code
- state_p2  in  4  fighter 2 state code
- char1_x  in  10  fighter 1 left x
- char2_x  in  10  fighter 2 left x
- fsm_hold  out  1  1 = fighter FSMs held in reset
- match_state  out  3  current phase code
- health_p1  out  2  fighter 1 health remaining
- health_p2  out  2  fighter 2 health remaining
- rounds_p1  out  2  rounds won by fighter 1
- rounds_p2  out  2  rounds won by fighter 2
- hit_p1  out  1  one-cycle pulse: fighter 1 was damaged
- hit_p2  out  1  one-cycle pulse: fighter 2 was damaged
- block_p1  out  1  one-cycle pulse: fighter 1 blocked a hit
- block_p2  out  1  one-cycle pulse: fighter 2 blocked a hit
- winner  out  2  0 none, 1 fighter 1, 2 fighter 2

Behaviour:
- Clock and reset: reset is asynchronous, active-high; all logic is clocked on clk_game.
- Reset values: match_state=MENU, fsm_hold=1, health_p1=health_p2=MAX_HEALTH, rounds_p1=rounds_p2=0, all pulses 0, winner=0, frame timer 0, hit latches 0.
- Reset mid-operation returns to MENU on the next reset deassertion, whatever phase was active.
- Phase encoding: MENU=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_OVER=4.
- fsm_hold is 0 only in FIGHT. It is registered, so it drops on the same edge that enters FIGHT.
- MENU -> COUNTDOWN on a start rising edge (start_button=1 this cycle and 0 the previous cycle). On this transition rounds, winner and health are cleared to their reset values.
- COUNTDOWN: the timer counts up from 0. At COUNTDOWN_FRAMES-1 the timer resets to 0 and the phase moves to FIGHT.
- FIGHT -> ROUND_END on the edge after either health register reaches 0.
  - If only one fighter is at 0, the opponent's round count increments on that transition.
  - If both are at 0 (a trade KO), it is a draw and no round is awarded.
- ROUND_END: the timer runs ROUND_END_FRAMES cycles.
  - If either round count equals ROUNDS_TO_WIN, the phase moves to MATCH_OVER and winner is set.
  - Otherwise the phase moves to COUNTDOWN, with both health registers reloaded to MAX_HEALTH on that edge.
- MATCH_OVER: winner holds. A start rising edge moves to MENU.
- Hit judging runs only in FIGHT.
  - Fighter 1 faces right when (char1_x + CHAR_WIDTH/2) < (char2_x + CHAR_WIDTH/2); fighter 2 faces the opposite way.
  - Gap = defender near edge minus attacker near edge, computed in 11 bits and saturated at 0 when the sprites overlap.
  - An attacker is active in state 4 (ATTACK_1_ACTIVE, reach REACH_ATK1) or state 7 (ATTACK_2_ACTIVE, reach REACH_ATK2).
  - Connect if the attacker is active, its hit latch is clear, and gap <= reach.
- Block rule: the defender blocks if it is in the move state pointing away from the attacker.
  - Fighter 2 is away in RIGHT (2) when fighter 1 is left of it; otherwise LEFT (1) is away.
  - The same rule applies symmetrically to fighter 1.
- On a connect, the registered outcome appears on the next edge:
  - If blocked: the defender's block pulse fires and health is unchanged.
  - If not blocked: the defender's hit pulse fires and its health decrements, saturating at 0.
  - In both cases the attacker's hit latch sets.
- Each attacker's hit latch clears when its state is neither 4 nor 7. This gives at most one hit per attack.
- Simultaneous connects from both fighters are both applied on the same edge (a trade).
- Pulses are forced to 0 outside FIGHT.
- Timer width is sized from the larger of COUNTDOWN_FRAMES and ROUND_END_FRAMES (8 bits at the defaults).

Decomposition:
- Shared package: fighter state codes 0..10 (IDLE, LEFT, RIGHT, ATTACK_1/2 STARTUP/ACTIVE/RECOVERY, DAMAGE, BLOCK), match phase codes, CHAR_WIDTH.
- The fighter FSM block and this block both import the package.
- One sub-module, hit_judge: combinational facing/gap/connect/block logic for one attacker-defender pair. It is instantiated twice with the ports swapped.

Test Plan:
- Reset, then start_button pulsed at cycle 5 -> match_state 1 for 120 cycles, then 2; fsm_hold falls on that edge.
- Fight with char1_x=300, char2_x=450 (gap 22), state_p1=4 for 4 cycles, state_p2=0 -> exactly one hit_p2 pulse; health_p2 goes 3 -> 2.
- Same positions, state_p2=2 (retreat) while state_p1=4 -> block_p2 pulse; health_p2 stays 3.
- char2_x=470 (gap 42), state_p1=4 -> no hit; state_p1=7 with gap 40 -> hit.
- Both fighters at health 1, both in state 4, gap 10 -> both hit pulses on the same edge, ROUND_END, rounds unchanged (draw).
- Fighter 1 wins 2 rounds -> MATCH_OVER, winner=1; assert reset during FIGHT -> MENU with all outputs at reset values.
